if_fetch_unit: RTL

Instruction-fetch stage directly upstream of `i_sram_interface`. Owns the PC, drives the instruction-RAM request side of `i_sram_interface`, and honours its `stall`. Delivers fetched words into a registered IF/ID slot with a one-entry skid buffer, and applies branch redirects and exception flushes without losing or duplicating a fetch.

---
 rtl/mips_defs_pkg.sv | 25 ++
 rtl/fetch_skid_buf.sv | 40 ++++
 rtl/if_fetch_unit.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/mips_defs_pkg.sv
// Shared definitions for the MIPS front end: reset vector, fetch FSM states,
// the {pc, instr, adel} fetch record, and small PC helpers.
package mips_defs_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'hBFC0_0000;
  localparam logic [31:0] INSTR_NOP    = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2,
    ADEL  = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        adel;
  } fetch_entry_t;

  function automatic logic pc_misaligned(input logic [31:0] pc);
    return pc[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer holding a fetched {pc, instr, adel} record that the
// IF/ID slot could not accept; clear and reset dominate load and unload.
module fetch_skid_buf
  import mips_defs_pkg::*;
(
  input  logic         clk,
  input  logic         resetn,
  input  logic         clear,
  input  logic         load,
  input  logic         unload,
  input  fetch_entry_t load_entry,
  output fetch_entry_t entry,
  output logic         full
);

  fetch_entry_t entry_r;
  logic         full_r;

  // Buffer storage and occupancy flag.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      entry_r <= '0;
      full_r  <= 1'b0;
    end else if (clear) begin
      entry_r <= '0;
      full_r  <= 1'b0;
    end else if (load) begin
      entry_r <= load_entry;
      full_r  <= 1'b1;
    end else if (unload) begin
      full_r  <= 1'b0;
    end else begin
      full_r  <= full_r;
    end
  end

  assign entry = entry_r;
  assign full  = full_r;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues requests to i_sram_interface,
// and delivers words into a registered IF/ID slot backed by a skid buffer.
module if_fetch_unit
  import mips_defs_pkg::*;
#(
  parameter logic [31:0] RESET_PC      = RESET_PC_DEF,
  parameter bit          FLUSH_ON_ADEL = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        instr_ram_ena,
  output logic [3:0]  instr_ram_wea,
  output logic [31:0] instr_ram_addr,
  output logic [31:0] instr_ram_w_data,
  input  logic [31:0] instr_ram_r_data,
  input  logic        i_stall,
  input  logic        id_stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        flush_valid,
  input  logic [31:0] flush_pc,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_adel
);

  fetch_state_e state_r, state_s;
  logic [31:0]  pc_q, pc_s;
  logic [31:0]  redir_q, redir_s;
  logic         redir_vld_q, redir_vld_s;
  logic [31:0]  drain_pc_r, drain_pc_s;
  logic         ena_r, ena_s;
  fetch_entry_t slot_r, slot_s;
  logic         slot_vld_r, slot_vld_s;

  logic         complete_s, slot_free_s, deliver_s;
  fetch_entry_t deliver_entry_s, skid_entry_s;
  logic         skid_full_s, skid_load_s, skid_unload_s, skid_clear_s;

  assign complete_s  = ena_r && !i_stall;
  assign slot_free_s = !slot_vld_r || !id_stall;

  fetch_skid_buf u_skid (
    .clk        (clk),
    .resetn     (resetn),
    .clear      (skid_clear_s),
    .load       (skid_load_s),
    .unload     (skid_unload_s),
    .load_entry (deliver_entry_s),
    .entry      (skid_entry_s),
    .full       (skid_full_s)
  );

  // Next-state, PC selection and IF/ID delivery.
  always_comb begin
    state_s         = state_r;
    pc_s            = pc_q;
    redir_s         = redir_q;
    redir_vld_s     = redir_vld_q;
    drain_pc_s      = drain_pc_r;
    slot_s          = slot_r;
    slot_vld_s      = slot_vld_r && id_stall;
    skid_load_s     = 1'b0;
    skid_unload_s   = 1'b0;
    skid_clear_s    = 1'b0;
    deliver_s       = 1'b0;
    deliver_entry_s = '0;
    case (state_r)
      FETCH: begin
        if (flush_valid) begin
          if (ena_r && i_stall) begin
            state_s    = DRAIN;
            drain_pc_s = flush_pc;
          end else begin
            pc_s = flush_pc;
          end
        end else if (complete_s) begin
          deliver_s       = 1'b1;
          deliver_entry_s = '{pc: pc_q, instr: instr_ram_r_data, adel: 1'b0};
          redir_vld_s     = 1'b0;
          if (redirect_valid) begin
            pc_s = redirect_pc;
          end else if (redir_vld_q) begin
            pc_s = redir_q;
          end else begin
            pc_s = pc_q + 32'd4;
          end
        end else if (ena_r) begin
          // Stalled fetch is the delay slot; park the target until it completes.
          if (redirect_valid) begin
            redir_vld_s = 1'b1;
            redir_s     = redirect_pc;
          end else begin
            redir_vld_s = redir_vld_q;
          end
        end else if (pc_misaligned(pc_q)) begin
          if (slot_free_s) begin
            deliver_s       = 1'b1;
            deliver_entry_s = '{pc: pc_q, instr: INSTR_NOP, adel: 1'b1};
            if (FLUSH_ON_ADEL) begin
              state_s = ADEL;
            end else begin
              pc_s = {pc_q[31:2] + 30'd1, 2'b00};
            end
          end else begin
            deliver_s = 1'b0;
          end
        end else begin
          if (redirect_valid) begin
            pc_s = redirect_pc;
          end else begin
            pc_s = pc_q;
          end
        end
        if (deliver_s) begin
          if (slot_free_s) begin
            slot_vld_s = 1'b1;
            slot_s     = deliver_entry_s;
          end else begin
            skid_load_s = 1'b1;
            state_s     = HOLD;
          end
        end else begin
          skid_load_s = 1'b0;
        end
      end
      HOLD: begin
        if (flush_valid) begin
          pc_s    = flush_pc;
          state_s = FETCH;
        end else begin
          if (redirect_valid) begin
            pc_s = redirect_pc;
          end else begin
            pc_s = pc_q;
          end
          if (slot_free_s) begin
            slot_vld_s    = 1'b1;
            slot_s        = skid_entry_s;
            skid_unload_s = 1'b1;
            state_s       = FETCH;
          end else begin
            skid_unload_s = 1'b0;
          end
        end
      end
      DRAIN: begin
        if (flush_valid) begin
          drain_pc_s = flush_pc;
        end else begin
          drain_pc_s = drain_pc_r;
        end
        // The returning word belongs to the flushed path and is dropped.
        if (!i_stall) begin
          state_s = FETCH;
          pc_s    = flush_valid ? flush_pc : drain_pc_r;
        end else begin
          state_s = DRAIN;
        end
      end
      ADEL: begin
        if (flush_valid) begin
          pc_s    = flush_pc;
          state_s = FETCH;
        end else begin
          state_s = ADEL;
        end
      end
      default: begin
        state_s = FETCH;
      end
    endcase
    if (flush_valid) begin
      slot_vld_s   = 1'b0;
      slot_s       = '0;
      skid_clear_s = 1'b1;
      skid_load_s  = 1'b0;
      redir_vld_s  = 1'b0;
    end else begin
      skid_clear_s = 1'b0;
    end
    ena_s = ((state_s == FETCH) && !pc_misaligned(pc_s)) || (state_s == DRAIN);
  end

  // State, PC and IF/ID slot registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r     <= FETCH;
      pc_q        <= RESET_PC;
      redir_q     <= 32'h0000_0000;
      redir_vld_q <= 1'b0;
      drain_pc_r  <= 32'h0000_0000;
      ena_r       <= 1'b0;
      slot_r      <= '0;
      slot_vld_r  <= 1'b0;
    end else begin
      state_r     <= state_s;
      pc_q        <= pc_s;
      redir_q     <= redir_s;
      redir_vld_q <= redir_vld_s;
      drain_pc_r  <= drain_pc_s;
      ena_r       <= ena_s;
      slot_r      <= slot_s;
      slot_vld_r  <= slot_vld_s;
    end
  end

  assign instr_ram_ena    = ena_r;
  assign instr_ram_wea    = 4'b0000;
  assign instr_ram_addr   = pc_q;
  assign instr_ram_w_data = 32'h0000_0000;
  assign if_valid         = slot_vld_r;
  assign if_pc            = slot_r.pc;
  assign if_instr         = slot_r.instr;
  assign if_adel          = slot_r.adel;

endmodule
